dcache_msi: RTL and testbench
=============================

DCACHE_MSI -- requirements
Module: dcache_msi

Interface
REQ-001 SHALL have port CLK, in, 1, system clock, rising edge.
REQ-002 SHALL have port nRST, in, 1, reset, asynchronous, active-low.
REQ-003 SHALL have ports dmemREN, dmemWEN, in, 1 each, datapath load/store request.
REQ-004 SHALL have ports dmemaddr and dmemstore, in, 32 each, datapath byte address and store data.
REQ-005 SHALL have ports dmemload, out, 32, and dhit, out, 1, load data and request-complete strobe.
REQ-006 SHALL have ports dREN and dWEN, out, 1 each, and daddr and dstore, out, 32 each, memory-controller data request.
REQ-007 SHALL have ports dload, in, 32, and dwait, in, 1, controller return data and word-done (low = done).
REQ-008 SHALL have ports cctrans and ccwrite, out, 1 each, coherence transaction and write-intent/dirty-supply flags.
REQ-009 SHALL have ports ccwait, ccinv, in, 1 each, and ccsnoopaddr, in, 32, snoop request, invalidate, snoop address.

Function
REQ-010 SHALL be direct-mapped, 16 sets, 2 words/block; tag = addr[31:7] (25b), index = addr[6:3], word = addr[2], addr[1:0] ignored.
REQ-011 SHALL keep per set: valid, dirty (M), tag, data[2]; state I = !valid, S = valid & !dirty, M = valid & dirty.
REQ-012 SHALL implement FSM states IDLE, WB0, WB1, FETCH0, FETCH1, SNOOP.
REQ-013 In IDLE, load hit (valid, tag match) SHALL assert dhit combinationally with dmemload = data[word], same cycle, no state change.
REQ-014 In IDLE, store hit on M SHALL assert dhit, write dmemstore into the word at the next edge.
REQ-015 Store hit on S SHALL go to FETCH0 with cctrans = 1, ccwrite = 1 (upgrade); data refetched, then word written and line set M.
REQ-016 Miss with victim M SHALL go WB0 -> WB1: dWEN = 1, daddr = {victim tag, index, word, 00}, dstore = victim word; advance on dwait = 0.
REQ-017 Miss with clean/invalid victim, or after WB1, SHALL go FETCH0 -> FETCH1: dREN = 1, cctrans = 1, ccwrite = dmemWEN, daddr word 0 then word 1; capture dload at dwait = 0.
REQ-018 After FETCH1 the line SHALL be valid with new tag, dirty = 0 for loads; stores then complete as M hit in IDLE next cycle.
REQ-019 ccwait = 1 while in IDLE SHALL take priority over any datapath request and enter SNOOP; dhit = 0 that cycle.
REQ-020 In SNOOP, hit on M at ccsnoopaddr SHALL assert ccwrite = 1 and dstore = data[ccsnoopaddr[2]]; line becomes S, or I if ccinv = 1.
REQ-021 In SNOOP, hit on S with ccinv = 1 SHALL invalidate; miss SHALL hold ccwrite = 0; exit to IDLE when ccwait falls.
REQ-022 ccwait asserted while in WB/FETCH states SHALL be ignored (controller never snoops the requester).
REQ-023 dREN, dWEN, cctrans, ccwrite SHALL be 0 in IDLE except as REQ-020; dhit SHALL be 0 outside IDLE.
REQ-024 Simultaneous dmemREN and dmemWEN SHALL be treated as a store.

Reset
REQ-025 nRST low SHALL asynchronously force IDLE, clear all valid and dirty bits, tags and data to 0.
REQ-026 Reset mid-transaction SHALL abandon it; all outputs 0 during reset; no writeback of dirty lines.

Configuration
REQ-027 With DCACHE_HITCNT_EN defined, SHALL provide output hitcnt (32b) counting dhit cycles, reset 0, wrapping at 2^32-1 to 0.
REQ-028 Without DCACHE_HITCNT_EN, hitcnt port and counter SHALL be absent.

Structure
REQ-029 Line-state enum, tag/index/word field widths, and packed address struct SHALL live in cpu_types_pkg.
REQ-030 One sub-module dcache_array (tag/data/valid/dirty storage, one write port, two read ports: datapath and snoop) SHALL be used.

Verification
REQ-031 Reset, load 0x00000040 miss, dload 0xAAAA/0xBBBB -> two dREN words (0x40, 0x44), then dhit, dmemload = 0xAAAA.
REQ-032 Store 0x1234 to 0x44 after REQ-031 fill (S) -> cctrans = 1, ccwrite = 1 upgrade, then line M, load 0x44 returns 0x1234.
REQ-033 M line at index 8, load to 0x00000C40 -> WB0/WB1 dWEN to 0x40/0x44 with old data, then fetch of 0xC40/0xC44.
REQ-034 M line 0x40, ccwait = 1, ccsnoopaddr = 0x44, ccinv = 1 -> ccwrite = 1, dstore = word1, then load 0x40 misses.
REQ-035 ccwait = 1 with concurrent dmemREN hit -> dhit = 0 until ccwait falls, then dhit next IDLE cycle.
REQ-036 nRST pulse during FETCH1 -> IDLE, dREN = 0, prior fetched line invalid.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared data-cache types: address fields, line storage record and MSI line state.
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int TAG_W  = 25;
  localparam int IDX_W  = 4;
  localparam int SETS   = 16;

  typedef enum logic [1:0] {
    LS_I = 2'd0,
    LS_S = 2'd1,
    LS_M = 2'd2
  } line_state_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic             blkoff;
    logic [1:0]       bytoff;
  } dcachef_t;

  typedef struct packed {
    logic                       valid;
    logic                       dirty;
    logic [TAG_W-1:0]           tag;
    logic [1:0][WORD_W-1:0]     data;
  } dline_t;

  function automatic line_state_t line_state(input dline_t l);
    if (!l.valid) return LS_I;
    if (l.dirty)  return LS_M;
    return LS_S;
  endfunction

endpackage

// File: rtl/dcache_msi_if.sv
// Datapath, memory-controller and coherence signals of the MSI data cache.
interface dcache_msi_if;
  logic        dmemREN, dmemWEN;
  logic [31:0] dmemaddr, dmemstore, dmemload;
  logic        dhit;
  logic        dREN, dWEN;
  logic [31:0] daddr, dstore, dload;
  logic        dwait;
  logic        cctrans, ccwrite, ccwait, ccinv;
  logic [31:0] ccsnoopaddr;

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, dload, dwait, ccwait, ccinv, ccsnoopaddr,
    output dmemload, dhit, dREN, dWEN, daddr, dstore, cctrans, ccwrite
  );

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore, dload, dwait, ccwait, ccinv, ccsnoopaddr,
    input  dmemload, dhit, dREN, dWEN, daddr, dstore, cctrans, ccwrite
  );
endinterface

// File: rtl/dcache_array.sv
// Line storage for the direct-mapped cache: one whole-line write port,
// combinational read ports for the datapath and the snoop side.
module dcache_array
  import cpu_types_pkg::*;
(
  input  logic             CLK,
  input  logic             nRST,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  dline_t           wline,
  input  logic [IDX_W-1:0] ridx,
  output dline_t           rline,
  input  logic [IDX_W-1:0] sidx,
  output dline_t           sline
);

  dline_t lines [SETS];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < SETS; i++) lines[i] <= '0;
    end else if (we) begin
      lines[widx] <= wline;
    end
  end

  assign rline = lines[ridx];
  assign sline = lines[sidx];

endmodule

// File: rtl/dcache_msi.sv
// Direct-mapped write-back data cache with MSI snooping.
// Optional hit counter output enabled by DCACHE_HITCNT_EN.
//
// state  | meaning
// IDLE   | serve hits, dispatch misses/upgrades, accept snoops
// WB0    | write back victim word 0
// WB1    | write back victim word 1
// FETCH0 | fetch word 0 (bus read or read-exclusive)
// FETCH1 | fetch word 1, install line
// SNOOP  | answer a snoop until ccwait drops
module dcache_msi
  import cpu_types_pkg::*;
(
  input  logic         CLK,
  input  logic         nRST,
  dcache_msi_if.slave  dif
`ifdef DCACHE_HITCNT_EN
  ,
  output logic [31:0]  hitcnt
`endif
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] WB0    = 3'd1;
  localparam logic [2:0] WB1    = 3'd2;
  localparam logic [2:0] FETCH0 = 3'd3;
  localparam logic [2:0] FETCH1 = 3'd4;
  localparam logic [2:0] SNOOP  = 3'd5;

  logic [2:0]       state, next_state;
  logic [31:0]      fetch_w0;
  dcachef_t         a, sa;
  dline_t           rline, sline, wline;
  logic             we;
  logic [IDX_W-1:0] widx;
  logic             req, is_store, hit, shit;
  line_state_t      rstate, sstate;
  logic             unused_bytoff;

  assign a        = dcachef_t'(dif.dmemaddr);
  assign sa       = dcachef_t'(dif.ccsnoopaddr);
  assign unused_bytoff = ^{a.bytoff, sa.bytoff};
  assign is_store = dif.dmemWEN;
  assign req      = dif.dmemREN | dif.dmemWEN;
  assign hit      = rline.valid && (rline.tag == a.tag);
  assign shit     = sline.valid && (sline.tag == sa.tag);
  assign rstate   = line_state(rline);
  assign sstate   = line_state(sline);

  dcache_array u_array (
    .CLK   (CLK),
    .nRST  (nRST),
    .we    (we),
    .widx  (widx),
    .wline (wline),
    .ridx  (a.idx),
    .rline (rline),
    .sidx  (sa.idx),
    .sline (sline)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      fetch_w0 <= '0;
    end else begin
      state <= next_state;
      if (state == FETCH0 && !dif.dwait) fetch_w0 <= dif.dload;
    end
  end

  always_comb begin
    next_state   = state;
    we           = 1'b0;
    widx         = a.idx;
    wline        = rline;
    dif.dhit     = 1'b0;
    dif.dmemload = '0;
    dif.dREN     = 1'b0;
    dif.dWEN     = 1'b0;
    dif.daddr    = '0;
    dif.dstore   = '0;
    dif.cctrans  = 1'b0;
    dif.ccwrite  = 1'b0;
    case (state)
      IDLE: begin
        // Snoops win over the datapath so the bus never waits on us.
        if (dif.ccwait) begin
          next_state = SNOOP;
        end else if (req) begin
          if (hit && !is_store) begin
            dif.dhit     = 1'b1;
            dif.dmemload = rline.data[a.blkoff];
          end else if (hit && rstate == LS_M) begin
            dif.dhit                = 1'b1;
            we                      = 1'b1;
            wline.data[a.blkoff]    = dif.dmemstore;
          end else if (!hit && rstate == LS_M) begin
            next_state = WB0;
          end else begin
            next_state = FETCH0;
          end
        end
      end
      WB0: begin
        dif.dWEN   = 1'b1;
        dif.daddr  = {rline.tag, a.idx, 1'b0, 2'b00};
        dif.dstore = rline.data[0];
        if (!dif.dwait) next_state = WB1;
      end
      WB1: begin
        dif.dWEN   = 1'b1;
        dif.daddr  = {rline.tag, a.idx, 1'b1, 2'b00};
        dif.dstore = rline.data[1];
        if (!dif.dwait) next_state = FETCH0;
      end
      FETCH0: begin
        dif.dREN    = 1'b1;
        dif.cctrans = 1'b1;
        dif.ccwrite = is_store;
        dif.daddr   = {a.tag, a.idx, 1'b0, 2'b00};
        if (!dif.dwait) next_state = FETCH1;
      end
      FETCH1: begin
        dif.dREN    = 1'b1;
        dif.cctrans = 1'b1;
        dif.ccwrite = is_store;
        dif.daddr   = {a.tag, a.idx, 1'b1, 2'b00};
        if (!dif.dwait) begin
          // Stores install as M so the pending write retires as an M hit.
          we          = 1'b1;
          wline.valid = 1'b1;
          wline.dirty = is_store;
          wline.tag   = a.tag;
          wline.data  = {dif.dload, fetch_w0};
          next_state  = IDLE;
        end
      end
      SNOOP: begin
        widx = sa.idx;
        if (shit && sstate == LS_M) begin
          dif.ccwrite = 1'b1;
          dif.dstore  = sline.data[sa.blkoff];
        end
        if (!dif.ccwait) begin
          next_state = IDLE;
          if (shit) begin
            we          = 1'b1;
            wline       = sline;
            wline.dirty = 1'b0;
            if (dif.ccinv) wline.valid = 1'b0;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

`ifdef DCACHE_HITCNT_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)         hitcnt <= '0;
    else if (dif.dhit) hitcnt <= hitcnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_dcache_msi.sv
// Directed self-checking bench for dcache_msi with a small word memory model.
module tb_dcache_msi;

  logic CLK;
  logic nRST;
  dcache_msi_if bus ();
`ifdef DCACHE_HITCNT_EN
  logic [31:0] hitcnt;
`endif

  dcache_msi dut (
    .CLK  (CLK),
    .nRST (nRST),
    .dif  (bus)
`ifdef DCACHE_HITCNT_EN
    ,
    .hitcnt (hitcnt)
`endif
  );

  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic        cct;
    logic        ccw;
  } txn_t;

  txn_t        log_q [$];
  logic [31:0] mem [0:1023];
  logic        ph, stall_en, hold_wait;
  int          n_checks, n_errors;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign bus.dwait = hold_wait | (stall_en & ph);
  assign bus.dload = mem[bus.daddr[11:2]];

  always @(posedge CLK) begin
    txn_t t;
    ph <= ~ph;
    if (nRST && (bus.dREN || bus.dWEN) && !bus.dwait) begin
      t = {bus.dWEN, bus.daddr, (bus.dWEN ? bus.dstore : bus.dload), bus.cctrans, bus.ccwrite};
      log_q.push_back(t);
      if (bus.dWEN) mem[bus.daddr[11:2]] <= bus.dstore;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_txn(input string tag, input int i, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic ccw);
    txn_t t;
    t = '0;
    if (i < log_q.size()) t = log_q[i];
    check({tag, "_w"}, 32'(t.w), 32'(w));
    check({tag, "_addr"}, t.a, a);
    check({tag, "_data"}, t.d, d);
    if (!w) begin
      check({tag, "_cctrans"}, 32'(t.cct), 32'd1);
      check({tag, "_ccwrite"}, 32'(t.ccw), 32'(ccw));
    end
  endtask

  task automatic access(input logic ren, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata, output int lat);
    log_q.delete();
    @(posedge CLK); #1;
    bus.dmemREN   = ren;
    bus.dmemWEN   = wen;
    bus.dmemaddr  = addr;
    bus.dmemstore = wdata;
    @(negedge CLK);
    lat = 0;
    while (!bus.dhit && lat < 60) begin
      lat++;
      @(negedge CLK);
    end
    check("dhit_seen", 32'(bus.dhit), 32'd1);
    rdata = bus.dmemload;
    @(posedge CLK); #1;
    bus.dmemREN = 1'b0;
    bus.dmemWEN = 1'b0;
  endtask

  task automatic snoop(input string tag, input logic [31:0] saddr, input logic inv,
                       input logic exp_ccw, input logic [31:0] exp_data);
    @(posedge CLK); #1;
    bus.ccwait      = 1'b1;
    bus.ccsnoopaddr = saddr;
    bus.ccinv       = inv;
    @(negedge CLK);
    @(negedge CLK);
    check({tag, "_ccwrite"}, 32'(bus.ccwrite), 32'(exp_ccw));
    check({tag, "_dhit"}, 32'(bus.dhit), 32'd0);
    if (exp_ccw) check({tag, "_dstore"}, bus.dstore, exp_data);
    @(posedge CLK); #1;
    bus.ccwait = 1'b0;
    @(posedge CLK); #1;
    bus.ccinv = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          lat, n, hits;
    logic        any;

    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[10'h010] = 32'h0000AAAA;
    mem[10'h011] = 32'h0000BBBB;
    mem[10'h310] = 32'h0000CCCC;
    mem[10'h311] = 32'h0000DDDD;
    mem[10'h020] = 32'h00008080;
    mem[10'h021] = 32'h00008484;
    n_checks = 0; n_errors = 0;
    ph = 1'b0; stall_en = 1'b0; hold_wait = 1'b0;
    bus.dmemREN = 0; bus.dmemWEN = 0; bus.dmemaddr = 0; bus.dmemstore = 0;
    bus.ccwait = 0; bus.ccinv = 0; bus.ccsnoopaddr = 0;
    nRST = 1'b0;

    #12;
    check("rst_dREN", 32'(bus.dREN), 32'd0);
    check("rst_dhit", 32'(bus.dhit), 32'd0);
    @(negedge CLK); nRST = 1'b1;
    #1;
    check("idle_dWEN", 32'(bus.dWEN), 32'd0);
    check("idle_cctrans", 32'(bus.cctrans), 32'd0);
    check("idle_ccwrite", 32'(bus.ccwrite), 32'd0);
    check("idle_daddr", bus.daddr, 32'd0);
`ifdef DCACHE_HITCNT_EN
    check("hitcnt_rst", hitcnt, 32'd0);
`endif

    // cold miss fill
    access(1, 0, 32'h40, 0, rd, lat);
    check("fill_load", rd, 32'h0000AAAA);
    check("fill_n", log_q.size(), 32'd2);
    chk_txn("fill0", 0, 0, 32'h40, 32'h0000AAAA, 0);
    chk_txn("fill1", 1, 0, 32'h44, 32'h0000BBBB, 0);

    access(1, 0, 32'h44, 0, rd, lat);
    check("hit_load", rd, 32'h0000BBBB);
    check("hit_lat", lat, 32'd0);
    check("hit_n", log_q.size(), 32'd0);

    // S -> M upgrade
    access(0, 1, 32'h44, 32'h1234, rd, lat);
    check("upg_n", log_q.size(), 32'd2);
    chk_txn("upg0", 0, 0, 32'h40, 32'h0000AAAA, 1);
    chk_txn("upg1", 1, 0, 32'h44, 32'h0000BBBB, 1);
    access(1, 0, 32'h44, 0, rd, lat);
    check("upg_load", rd, 32'h1234);
    check("upg_lat", lat, 32'd0);

    // dirty victim writeback with stalled controller
    stall_en = 1'b1;
    access(1, 0, 32'hC40, 0, rd, lat);
    stall_en = 1'b0;
    check("wb_n", log_q.size(), 32'd4);
    chk_txn("wb0", 0, 1, 32'h40, 32'h0000AAAA, 0);
    chk_txn("wb1", 1, 1, 32'h44, 32'h1234, 0);
    chk_txn("wbf0", 2, 0, 32'hC40, 32'h0000CCCC, 0);
    chk_txn("wbf1", 3, 0, 32'hC44, 32'h0000DDDD, 0);
    check("wb_load", rd, 32'h0000CCCC);

    // store miss over clean victim, then M hit store
    access(0, 1, 32'h40, 32'h5555, rd, lat);
    check("smiss_n", log_q.size(), 32'd2);
    chk_txn("smiss0", 0, 0, 32'h40, 32'h0000AAAA, 1);
    access(0, 1, 32'h44, 32'h6666, rd, lat);
    check("mhit_n", log_q.size(), 32'd0);
    check("mhit_lat", lat, 32'd0);

    // snoop M with invalidate
    snoop("snp_m", 32'h44, 1, 1, 32'h6666);
    access(1, 0, 32'h40, 0, rd, lat);
    check("postinv_n", log_q.size(), 32'd2);
    chk_txn("postinv0", 0, 0, 32'h40, 32'h0000AAAA, 0);
    check("postinv_load", rd, 32'h0000AAAA);

    snoop("snp_miss", 32'h80, 1, 0, 32'h0);
    snoop("snp_s", 32'h40, 0, 0, 32'h0);
    access(1, 0, 32'h44, 0, rd, lat);
    check("snp_s_keep_n", log_q.size(), 32'd0);
    check("snp_s_keep_load", rd, 32'h1234);

    // snoop beats a concurrent hit
    @(posedge CLK); #1;
    bus.ccwait = 1'b1; bus.ccsnoopaddr = 32'h200;
    bus.dmemREN = 1'b1; bus.dmemaddr = 32'h40;
    any = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      any = any | bus.dhit;
    end
    check("prio_dhit", 32'(any), 32'd0);
    @(posedge CLK); #1;
    bus.ccwait = 1'b0;
    n = 0;
    @(negedge CLK);
    while (!bus.dhit && n < 10) begin
      n++;
      @(negedge CLK);
    end
    check("prio_resume", n, 32'd1);
    check("prio_load", bus.dmemload, 32'h0000AAAA);
    @(posedge CLK); #1;
    bus.dmemREN = 1'b0;

    // REN and WEN together behave as a store
    access(1, 1, 32'h40, 32'h7777, rd, lat);
    check("rw_n", log_q.size(), 32'd2);
    chk_txn("rw0", 0, 0, 32'h40, 32'h0000AAAA, 1);
    access(1, 0, 32'h40, 0, rd, lat);
    check("rw_load", rd, 32'h7777);

    // reset in FETCH1
    log_q.delete();
    @(posedge CLK); #1;
    bus.dmemREN = 1'b1; bus.dmemaddr = 32'h80;
    n = 0;
    @(negedge CLK);
    while (!(bus.dREN && bus.daddr == 32'h84) && n < 20) begin
      n++;
      @(negedge CLK);
    end
    hold_wait = 1'b1;
    check("f1_addr", bus.daddr, 32'h84);
    @(negedge CLK);
    check("f1_dREN", 32'(bus.dREN), 32'd1);
    #2 nRST = 1'b0;
    #1;
    check("midrst_dREN", 32'(bus.dREN), 32'd0);
    check("midrst_cctrans", 32'(bus.cctrans), 32'd0);
    check("midrst_dhit", 32'(bus.dhit), 32'd0);
    check("midrst_daddr", bus.daddr, 32'd0);
    bus.dmemREN = 1'b0;
    hold_wait = 1'b0;
    @(negedge CLK); nRST = 1'b1;
`ifdef DCACHE_HITCNT_EN
    #1 check("hitcnt_rst2", hitcnt, 32'd0);
`endif
    access(1, 0, 32'h80, 0, rd, lat);
    check("after_rst_n", log_q.size(), 32'd2);
    check("after_rst_load", rd, 32'h00008080);
`ifdef DCACHE_HITCNT_EN
    check("hitcnt_one", hitcnt, 32'd1);
`endif
    access(1, 0, 32'h40, 0, rd, lat);
    check("rst_inv_n", log_q.size(), 32'd2);
    chk_txn("rst_inv0", 0, 0, 32'h40, 32'h0000AAAA, 0);
    check("rst_nowb_load", rd, 32'h0000AAAA);

    hits = n_checks - n_errors;
    if (hits < 0) n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
